// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router datapath.
package router_pkg;

    localparam int unsigned ROUTER_DATA_W     = 8;
    localparam int unsigned ROUTER_FIFO_DEPTH = 16;
    localparam int unsigned PKT_LEN_W         = 7;
    localparam int unsigned HDR_LEN_W         = 6;

    typedef struct packed {
        logic       hdr;
        logic [7:0] data;
    } fifo_entry_t;

    typedef logic [PKT_LEN_W-1:0] pkt_len_t;

    // Payload length carried in the upper six bits of a header byte.
    function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [7:0] b);
        return b[7:2];
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-destination output FIFO: buffers header/payload/parity bytes and tracks
// how many bytes of the packet currently being read are still outstanding.
module router_fifo
    import router_pkg::*;
#(
    parameter int unsigned DEPTH  = ROUTER_FIFO_DEPTH,
    parameter int unsigned DATA_W = ROUTER_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              pkt_busy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    pkt_len_t         pkt_remain;
    pkt_len_t         pkt_nxt;
    logic             wr_acc;
    logic             rd_acc;
    logic [DATA_W:0]  rd_entry;

    // Acceptance, occupancy and packet-length bookkeeping.
    always_comb begin
        wr_acc    = write_enb && !full;
        rd_acc    = read_enb && !empty;
        rd_entry  = mem[rd_ptr];
        count_nxt = count;
        pkt_nxt   = pkt_remain;

        if (wr_acc && !rd_acc) begin
            count_nxt = count + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - CNT_W'(1);
        end

        // A header reloads the counter with payload length plus the parity byte;
        // stray non-header bytes with no packet open leave it at zero.
        if (rd_acc) begin
            if (rd_entry[DATA_W]) begin
                pkt_nxt = pkt_len_t'(hdr_len(rd_entry[7:0])) + pkt_len_t'(1);
            end else if (pkt_remain != '0) begin
                pkt_nxt = pkt_remain - pkt_len_t'(1);
            end
        end
    end

    // Storage is not reset; a flush only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc && !soft_reset) begin
            mem[wr_ptr] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pkt_remain <= '0;
            data_out   <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            pkt_busy   <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pkt_remain <= '0;
            data_out   <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            pkt_busy   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                data_out <= rd_entry[DATA_W-1:0];
            end
            count      <= count_nxt;
            pkt_remain <= pkt_nxt;
            full       <= (count_nxt == CNT_W'(DEPTH));
            empty      <= (count_nxt == '0);
            pkt_busy   <= (pkt_nxt != '0);
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: stimulus pushes expected read bytes,
// a monitor pops and compares whenever a read is accepted.
module tb_router_fifo;

    logic       clk;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       pkt_busy;

    int         n_tests;
    int         n_fail;
    logic [7:0] exp_q[$];

    router_fifo #(.DEPTH(16), .DATA_W(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_busy   (pkt_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Apply inputs for one clock, then return at the following negedge idle.
    task automatic drive(input logic we, input logic lfd, input logic [7:0] din, input logic re);
        write_enb = we;
        lfd_state = lfd;
        data_in   = din;
        read_enb  = re;
        @(posedge clk);
        @(negedge clk);
        write_enb = 1'b0;
        lfd_state = 1'b0;
        read_enb  = 1'b0;
    endtask

    // Monitor: a read accepted at posedge delivers data_out by the next negedge.
    initial begin
        logic       fire;
        logic [7:0] exp_b;
        forever begin
            @(posedge clk);
            fire = read_enb && !empty && resetn && !soft_reset;
            @(negedge clk);
            if (fire) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got 0x%0h expected no read", data_out);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("rd_data", 32'(data_out), 32'(exp_b));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        resetn     = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        lfd_state  = 1'b0;
        data_in    = 8'h00;
        read_enb   = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_busy", 32'(pkt_busy), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        resetn = 1'b1;

        // Half fill with a header (len 2), read it, then async reset mid-cycle
        drive(1'b1, 1'b1, 8'h08, 1'b0);
        exp_q.push_back(8'h08);
        for (int i = 1; i < 8; i++) drive(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("pre_rst_busy", 32'(pkt_busy), 32'd1);
        chk("pre_rst_remain", 32'(dut.pkt_remain), 32'd3);
        #2 resetn = 1'b0;
        #1;
        chk("async_dout", 32'(data_out), 32'd0);
        chk("async_empty", 32'(empty), 32'd1);
        chk("async_full", 32'(full), 32'd0);
        chk("async_busy", 32'(pkt_busy), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("rd_empty_dout", 32'(data_out), 32'd0);
        chk("rd_empty_empty", 32'(empty), 32'd1);

        // Fill and overflow
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
            exp_q.push_back(8'(8'h10 + i));
            if (i == 14) chk("fill15_full", 32'(full), 32'd0);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_empty", 32'(empty), 32'd0);
        drive(1'b1, 1'b0, 8'hAA, 1'b0);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_count", 32'(dut.count), 32'd16);
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_full", 32'(full), 32'd0);

        // Packet drain: header len 3, three payload bytes, parity
        drive(1'b1, 1'b1, 8'h0D, 1'b0); exp_q.push_back(8'h0D);
        drive(1'b1, 1'b0, 8'h01, 1'b0); exp_q.push_back(8'h01);
        drive(1'b1, 1'b0, 8'h02, 1'b0); exp_q.push_back(8'h02);
        drive(1'b1, 1'b0, 8'h03, 1'b0); exp_q.push_back(8'h03);
        drive(1'b1, 1'b0, 8'h0F, 1'b0); exp_q.push_back(8'h0F);
        chk("pkt_idle_busy", 32'(pkt_busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            chk("pkt_remain", 32'(dut.pkt_remain), 32'(4 - i));
            chk("pkt_busy", 32'(pkt_busy), (i < 4) ? 32'd1 : 32'd0);
        end
        chk("pkt_empty", 32'(empty), 32'd1);

        // Simultaneous write/read at full: only the read is taken
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
            exp_q.push_back(8'(8'h40 + i));
        end
        chk("simfull_pre", 32'(full), 32'd1);
        drive(1'b1, 1'b0, 8'hBB, 1'b1);
        chk("simfull_count", 32'(dut.count), 32'd15);
        chk("simfull_full", 32'(full), 32'd0);
        for (int i = 0; i < 15; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("simfull_empty", 32'(empty), 32'd1);

        // Simultaneous write/read mid-level across pointer wrap
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'(8'h50 + i), 1'b0);
            exp_q.push_back(8'(8'h50 + i));
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 8'(8'h60 + i), 1'b1);
            exp_q.push_back(8'(8'h60 + i));
        end
        chk("mid_count", 32'(dut.count), 32'd5);
        chk("mid_full", 32'(full), 32'd0);
        chk("mid_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("mid_drain_empty", 32'(empty), 32'd1);

        // soft_reset mid-packet overrides a concurrent write
        drive(1'b1, 1'b1, 8'h0D, 1'b0); exp_q.push_back(8'h0D);
        drive(1'b1, 1'b0, 8'h01, 1'b0); exp_q.push_back(8'h01);
        drive(1'b1, 1'b0, 8'h02, 1'b0);
        drive(1'b1, 1'b0, 8'h03, 1'b0);
        drive(1'b1, 1'b0, 8'h0F, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("sr_pre_remain", 32'(dut.pkt_remain), 32'd3);
        chk("sr_pre_busy", 32'(pkt_busy), 32'd1);
        soft_reset = 1'b1;
        drive(1'b1, 1'b0, 8'h77, 1'b0);
        soft_reset = 1'b0;
        chk("sr_empty", 32'(empty), 32'd1);
        chk("sr_busy", 32'(pkt_busy), 32'd0);
        chk("sr_dout", 32'(data_out), 32'd0);
        chk("sr_count", 32'(dut.count), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("sr_rd_dout", 32'(data_out), 32'd0);
        chk("sr_rd_empty", 32'(empty), 32'd1);

        chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
Per-destination output FIFO of the 1x3 router. It sits between the input/synchroniser stage and the read side of the router interface. It buffers header, payload and parity bytes written by the upstream FSM, and presents them on data_out when the read driver asserts read_enb. It tracks packet length from each header so the top level knows when a packet has fully drained.

Parameters:
DEPTH, 16, number of entries (power of two, ≥4)
DATA_W, 8, byte width of data_in/data_out

Ports:
clk  input  1  system clock, all state on posedge
resetn  input  1  asynchronous active-low reset
soft_reset  input  1  synchronous flush from upstream timeout logic, active-high
write_enb  input  1  write request for data_in this cycle
lfd_state  input  1  marks the byte being written as a header
data_in  input  DATA_W  byte to store
read_enb  input  1  read request from read driver
data_out  output  DATA_W  registered read data
full  output  1  no free entries
empty  output  1  no stored entries; top level drives vld_out = ~empty
pkt_busy  output  1  a read packet is in progress (remaining count ≠ 0)

Behaviour:
- Clocking and reset: one clock, clk. resetn is asynchronous, active-low.
- resetn low: all of the following clear immediately, independent of clk.
  - wr_ptr, rd_ptr, count, pkt_remain = 0
  - data_out = 0
  - empty = 1, full = 0, pkt_busy = 0
  - Storage contents need not be cleared.
- soft_reset high at posedge: same clearing as resetn, but synchronous. Overrides any write or read in that cycle.
- Storage: each entry is DATA_W+1 bits, {hdr, data}. hdr holds lfd_state captured at write time.
- Write accepted: write_enb && !full. Stores {lfd_state, data_in} at wr_ptr, then wr_ptr++.
- Read accepted: read_enb && !empty. data_out is loaded with the entry's data at the next posedge (latency 1), then rd_ptr++.
- No accepted read: data_out holds its previous value.
- full and empty are evaluated on the pre-edge count.
- Both accepted in one cycle: count unchanged, both pointers advance.
- full with both write_enb and read_enb: only the read is accepted, the write byte is dropped, count decrements.
- empty with both asserted: only the write is accepted, no bypass. Data becomes readable the following cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count is log2(DEPTH)+1 bits; full = (count == DEPTH), empty = (count == 0).
- Packet counter pkt_remain is 7 bits:
  - Accepted read of a hdr=1 entry: load pkt_remain = data[7:2] + 1 (payload length plus parity byte).
  - Accepted read of a hdr=0 entry with pkt_remain ≠ 0: pkt_remain--.
  - Accepted read of a hdr=0 entry with pkt_remain = 0 (stray byte): pkt_remain stays 0; data is still delivered.
  - pkt_busy = (pkt_remain ≠ 0), registered.
- Header length 0: pkt_remain = 1, so only the parity byte follows.
- Writes during an active read packet are unrestricted; the FIFO holds multiple packets back-to-back.

Decomposition:
- router_pkg holds:
  - ROUTER_DATA_W = 8
  - ROUTER_FIFO_DEPTH = 16
  - typedef struct packed {logic hdr; logic [7:0] data;} fifo_entry_t
  - typedef logic [6:0] pkt_len_t
  - function hdr_len(byte) returning byte[7:2]
- No sub-module. The storage array, pointer logic and packet counter live inline in router_fifo.
- The top level instantiates three router_fifo, one per destination.

Test Plan:
- Reset values: assert resetn=0 asynchronously mid-cycle with the FIFO half full → data_out=0, empty=1, full=0, pkt_busy=0 before the next posedge. After release, a read with empty=1 leaves data_out=0.
- Fill and overflow: write 16 bytes 0x10..0x1F → full=1 after the 16th. A 17th write of 0xAA is dropped. 16 reads return 0x10..0x1F in order, then empty=1.
- Packet drain:
  - Write header 0x0D (lfd_state=1, len=3), payload 0x01 0x02 0x03, then parity 0x0F.
  - Read 5 times → data_out 0x0D,01,02,03,0F on consecutive cycles.
  - pkt_remain goes 4,3,2,1,0; pkt_busy drops after the parity read.
- Simultaneous at full: with count=16, assert write_enb and read_enb together → read accepted, write dropped, count=15, full=0.
- Simultaneous mid-level: with count=5, hold both for 20 cycles → count stays 5 and data order is preserved across pointer wrap.
- soft_reset mid-packet: after reading the header and 1 payload byte (pkt_remain=3), pulse soft_reset with write_enb=1 → empty=1, pkt_busy=0, that write is discarded, data_out=0.
